// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd requester slice.
//   gcd_req_state_t : requester FSM state encoding
//   GCD_WIDTH       : default operand/result width
//   GCD_TIMEOUT     : default WAIT cycle budget before abandoning an operation
//   GCD_DEPTH       : default request FIFO depth
package gcd_pkg;

  localparam int GCD_WIDTH   = 32;
  localparam int GCD_TIMEOUT = 1024;
  localparam int GCD_DEPTH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    FLUSH
  } gcd_req_state_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Request FIFO for the gcd requester: synchronous push/pop, no bypass.
// A push is refused whenever the FIFO is full, even if a pop happens in
// the same cycle.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset (empties the FIFO)
//   push_i      : write push_data_i when not full
//   push_data_i : entry to write
//   pop_i       : drop the head entry when not empty
//   pop_data_o  : current head entry
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   count_o     : occupancy, 0..DEPTH
module gcd_req_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign pop_data_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the gcd start/done engine protocol. Buffers operand
// pairs, issues them one at a time to a single gcd engine, and returns the
// result (or a timeout marker) on a valid/ready response stream.
//   clk, reset              : clock; asynchronous active-low reset
//   req_valid/ready/a/b     : request stream (operand pair)
//   rsp_valid/ready         : response stream handshake
//   rsp_result, rsp_timeout : result, or 0 with timeout flag set
//   eng_start, eng_a, eng_b : one-cycle start pulse and held operands
//   eng_result, eng_done    : engine result and done level
//   busy                    : operation in progress or work queued
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; pops the FIFO head into eng_a/eng_b if present
// ISSUE | eng_start high for this cycle only; timer cleared
// WAIT  | waiting for eng_done or the timer reaching TIMEOUT-1
// RESP  | rsp_valid high, result held until rsp_ready
// FLUSH | abandoned operation: wait for eng_done and discard its result
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = GCD_DEPTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_timeout,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic [WIDTH-1:0] eng_result,
  input  logic             eng_done,
  output logic             busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  gcd_req_state_t   state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d;
  logic [WIDTH-1:0] eng_b_q, eng_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             flush_q, flush_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [2*WIDTH-1:0] fifo_head;

  gcd_req_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_valid),
    .push_data_i ({req_a, req_b}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign req_ready   = !fifo_full;
  assign eng_start   = (state_q == ISSUE);
  assign rsp_valid   = (state_q == RESP);
  assign eng_a       = eng_a_q;
  assign eng_b       = eng_b_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    eng_a_d       = eng_a_q;
    eng_b_d       = eng_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    flush_d       = flush_q;
    fifo_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          eng_a_d  = fifo_head[2*WIDTH-1:WIDTH];
          eng_b_d  = fifo_head[WIDTH-1:0];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // eng_done is not looked at here: any level now belongs to the
        // previous operation and is cleared by the engine on this edge.
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rsp_result_d  = eng_result;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          flush_d       = 1'b1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // The abandoned operation must finish before the engine is reused.
        if (eng_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      eng_a_q       <= '0;
      eng_b_q       <= '0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      eng_a_q       <= eng_a_d;
      eng_b_q       <= eng_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      flush_q       <= flush_d;
    end
  end

endmodule
